alu_sequencer: RTL and testbench

Multi-cycle issue controller on the initiator side of the combinational ALU. It accepts one operation per Start/Done handshake from the core, then drives the ALU's operand, opcode and carry-in lines. For shift and mask operations it iterates single-bit ALU steps, feeding each ALU output back as the next operand. It captures the final ALU output and status flags into registers for the core.

---
 rtl/alu_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle issue controller driving a combinational ALU.
// Accepts one request per Start/Done handshake, iterates single-bit shift
// steps for LSL/LSR/MSK, and registers the final ALU result and flags.
// Optional feature macro: ALU_SEQ_SAT_EN (shift/mask amounts >= W clamp to W).
module alu_sequencer #(
  parameter int W   = 8,
  parameter int Ops = 3,
  parameter int SW  = 3
) (
  input  logic           Clk,
  input  logic           Reset_n,
  input  logic           Start,
  input  logic [Ops-1:0] OpIn,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           Busy,
  output logic           Done,
  output logic           Err,
  output logic [W-1:0]   Result,
  output logic           FlagZero,
  output logic           FlagParity,
  output logic           FlagOdd,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  output logic [Ops-1:0] AluOp,
  output logic           AluSC,
  input  logic [W-1:0]   AluOut,
  input  logic           AluZero,
  input  logic           AluParity,
  input  logic           AluOdd
);

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_LSL = Ops'(1);
  localparam logic [Ops-1:0] OP_LSR = Ops'(2);
  localparam logic [Ops-1:0] OP_XOR = Ops'(3);
  localparam logic [Ops-1:0] OP_SNE = Ops'(4);
  localparam logic [Ops-1:0] OP_SEQ = Ops'(5);
  localparam logic [Ops-1:0] OP_MSK = Ops'(6);

  localparam logic [SW:0]  CNT_ONE = (SW+1)'(1);
  localparam logic [SW:0]  CNT_MAX = (SW+1)'(W);
  localparam logic [W-1:0] W_VAL   = W'(W);
  localparam logic [W-1:0] ONE_W   = W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state;
  logic [Ops-1:0] op_reg;
  logic [W-1:0]   a_reg;
  logic [SW:0]    cnt;
  logic           illegal;
  logic [SW:0]    step_n;

`ifdef ALU_SEQ_SAT_EN
  // Step count: any amount at or beyond the word width saturates to W
  always_comb begin
    step_n = {1'b0, B[SW-1:0]};
    if (B >= W_VAL) step_n = CNT_MAX;
  end
`else
  // Step count: amount taken modulo W
  always_comb begin
    step_n = {1'b0, B[SW-1:0]};
  end
`endif

  // Carry/shift-in to the ALU is never used
  assign AluSC = 1'b0;

  // Sequencer FSM; AluA doubles as the step accumulator while in STEP
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Result     <= '0;
      FlagZero   <= 1'b1;
      FlagParity <= 1'b0;
      FlagOdd    <= 1'b0;
      AluA       <= '0;
      AluB       <= '0;
      AluOp      <= OP_ADD;
      op_reg     <= OP_ADD;
      a_reg      <= '0;
      cnt        <= '0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          Done <= 1'b0;
          Err  <= 1'b0;
          if (Start) begin
            Busy    <= 1'b1;
            op_reg  <= OpIn;
            a_reg   <= A;
            cnt     <= step_n;
            illegal <= 1'b0;
            case (OpIn)
              OP_ADD, OP_XOR, OP_SNE, OP_SEQ: begin
                state <= S_EXEC;
                AluOp <= OpIn;
                AluA  <= A;
                AluB  <= B;
              end
              OP_LSL, OP_LSR: begin
                if (step_n != '0) begin
                  state <= S_STEP;
                  AluOp <= OpIn;
                  AluA  <= A;
                  AluB  <= ONE_W;
                end else begin
                  // Zero-length shift degenerates to A+0
                  state <= S_EXEC;
                  AluOp <= OP_ADD;
                  AluA  <= A;
                  AluB  <= '0;
                end
              end
              OP_MSK: begin
                if (step_n != '0) begin
                  // Build the mask 1<<n by shifting a seed of 1
                  state <= S_STEP;
                  AluOp <= OP_LSL;
                  AluA  <= ONE_W;
                  AluB  <= ONE_W;
                end else begin
                  state <= S_EXEC;
                  AluOp <= OP_XOR;
                  AluA  <= A;
                  AluB  <= ONE_W;
                end
              end
              default: begin
                // Illegal opcode spends its EXEC slot with the ALU left idle
                state   <= S_EXEC;
                illegal <= 1'b1;
              end
            endcase
          end
        end

        S_STEP: begin
          AluA       <= AluOut;
          FlagZero   <= AluZero;
          FlagParity <= AluParity;
          FlagOdd    <= AluOdd;
          cnt        <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (op_reg == OP_MSK) begin
              state <= S_EXEC;
              AluOp <= OP_XOR;
              AluA  <= a_reg;
              AluB  <= AluOut;
            end else begin
              state  <= S_DONE;
              Done   <= 1'b1;
              Result <= AluOut;
              AluOp  <= OP_ADD;
              AluA   <= '0;
              AluB   <= '0;
            end
          end
        end

        S_EXEC: begin
          state <= S_DONE;
          Done  <= 1'b1;
          AluOp <= OP_ADD;
          AluA  <= '0;
          AluB  <= '0;
          if (illegal) begin
            Err        <= 1'b1;
            Result     <= '0;
            FlagZero   <= 1'b1;
            FlagParity <= 1'b0;
            FlagOdd    <= 1'b0;
          end else begin
            Result     <= AluOut;
            FlagZero   <= AluZero;
            FlagParity <= AluParity;
            FlagOdd    <= AluOdd;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          Done  <= 1'b0;
          Err   <= 1'b0;
          Busy  <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven check of alu_sequencer against a behavioural
// ALU, plus hand-written sequences for busy-ignore and mid-operation reset.
// Honours ALU_SEQ_SAT_EN for the saturating-amount vectors.
module tb_alu_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] OpIn = '0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       Busy, Done, Err;
  logic [7:0] Result;
  logic       FlagZero, FlagParity, FlagOdd;
  logic [7:0] AluA, AluB;
  logic [2:0] AluOp;
  logic       AluSC;
  logic [7:0] AluOut;
  logic       AluZero, AluParity, AluOdd;

  int checks = 0;
  int failures = 0;

  alu_sequencer #(.W(8), .Ops(3), .SW(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .OpIn(OpIn), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Err(Err), .Result(Result),
    .FlagZero(FlagZero), .FlagParity(FlagParity), .FlagOdd(FlagOdd),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluSC(AluSC),
    .AluOut(AluOut), .AluZero(AluZero), .AluParity(AluParity), .AluOdd(AluOdd)
  );

  always #5 Clk = ~Clk;

  // Behavioural combinational ALU on the far side of the sequencer
  logic [7:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (AluOp)
      3'd0: alu_res = AluA + AluB;
      3'd1: alu_res = AluA << AluB;
      3'd2: alu_res = AluA >> AluB;
      3'd3: alu_res = AluA ^ AluB;
      3'd4: alu_res = {7'd0, AluA != AluB};
      3'd5: alu_res = {7'd0, AluA == AluB};
      default: alu_res = '0;
    endcase
  end
  assign AluOut    = alu_res;
  assign AluZero   = (alu_res == 8'd0);
  assign AluParity = ^alu_res;
  assign AluOdd    = alu_res[0];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       p;
    logic       o;
    logic       err;
    int         lat;
    int         steps;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency/step cycles, check outputs at Done.
  // poke_cycle > 0 injects an opcode-0 Start during that busy cycle.
  task automatic run_op(input int idx, input vec_t v, input int poke_cycle);
    int lat;
    int steps;
    bit got;
    bit extra;
    lat = 0; steps = 0; got = 0; extra = 0;
    @(negedge Clk);
    Start = 1'b1; OpIn = v.op; A = v.a; B = v.b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (k == 1) Start = 1'b0;
      if (poke_cycle != 0 && k == poke_cycle) begin
        Start = 1'b1; OpIn = 3'd0; A = 8'h11; B = 8'h22;
      end
      if (poke_cycle != 0 && k == poke_cycle + 1) Start = 1'b0;
      if (AluB == 8'd1 && (AluOp == 3'd1 || AluOp == 3'd2)) steps++;
      if (Done) begin
        got = 1; lat = k;
        break;
      end
    end
    Start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(v.lat));
    check("step_cycles", 32'(steps), 32'(v.steps));
    check("result", 32'(Result), 32'(v.res));
    check("flags", {29'd0, FlagZero, FlagParity, FlagOdd}, {29'd0, v.z, v.p, v.o});
    check("err", 32'(Err), 32'(v.err));
    @(negedge Clk);
    check("idle_after", {30'd0, Done, Busy}, 32'd0);
    check("result_hold", 32'(Result), 32'(v.res));
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (Done) extra = 1;
    end
    check("no_extra_done", 32'(extra), 32'd0);
    $display("op[%0d] op=%0d a=%02h b=%02h -> res=%02h zpo=%b%b%b err=%b lat=%0d steps=%0d",
             idx, v.op, v.a, v.b, Result, FlagZero, FlagParity, FlagOdd, v.err, lat, steps);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy_done_err"}, {29'd0, Busy, Done, Err}, 32'd0);
    check({tag, "_result"}, 32'(Result), 32'd0);
    check({tag, "_flags"}, {29'd0, FlagZero, FlagParity, FlagOdd}, 32'd4);
    check({tag, "_alu_ab"}, {16'd0, AluA, AluB}, 32'd0);
    check({tag, "_alu_op_sc"}, {28'd0, AluOp, AluSC}, 32'd0);
  endtask

  initial begin
    vec_t v;
    bit   saw_done;
    //              op     a      b      res    z  p  o  err lat steps
    vecs[0]  = '{3'd0, 8'h7F, 8'h81, 8'h00, 1, 0, 0, 0, 2, 0};  // ADD wrap
    vecs[1]  = '{3'd1, 8'h03, 8'd3,  8'h18, 0, 0, 0, 0, 4, 3};  // LSL x3
    vecs[2]  = '{3'd6, 8'h00, 8'd6,  8'h40, 0, 1, 0, 0, 8, 6};  // MSK 6
    vecs[3]  = '{3'd6, 8'hFF, 8'd0,  8'hFE, 0, 1, 0, 0, 2, 0};  // MSK 0
    vecs[4]  = '{3'd3, 8'hA5, 8'h0F, 8'hAA, 0, 0, 0, 0, 2, 0};  // XOR
    vecs[5]  = '{3'd4, 8'h12, 8'h13, 8'h01, 0, 1, 1, 0, 2, 0};  // SNE true
    vecs[6]  = '{3'd5, 8'h12, 8'h12, 8'h01, 0, 1, 1, 0, 2, 0};  // SEQ true
    vecs[7]  = '{3'd5, 8'h12, 8'h13, 8'h00, 1, 0, 0, 0, 2, 0};  // SEQ false
    vecs[8]  = '{3'd2, 8'hF0, 8'd4,  8'h0F, 0, 0, 1, 0, 5, 4};  // LSR x4
    vecs[9]  = '{3'd1, 8'h05, 8'd0,  8'h05, 0, 0, 1, 0, 2, 0};  // LSL 0 -> ADD
    vecs[10] = '{3'd7, 8'h55, 8'd3,  8'h00, 1, 0, 0, 1, 2, 0};  // illegal
    vecs[11] = '{3'd6, 8'h0F, 8'd3,  8'h07, 0, 1, 1, 0, 5, 3};  // MSK 3
    vecs[12] = '{3'd1, 8'h81, 8'd1,  8'h02, 0, 1, 0, 0, 2, 1};  // LSL carry lost
`ifdef ALU_SEQ_SAT_EN
    vecs[13] = '{3'd2, 8'h80, 8'd9,  8'h00, 1, 0, 0, 0, 9, 8};  // LSR clamps to 8
    vecs[14] = '{3'd6, 8'h3C, 8'd8,  8'h3C, 0, 0, 0, 0, 10, 8}; // MSK mask gone
`else
    vecs[13] = '{3'd2, 8'h80, 8'd9,  8'h40, 0, 1, 0, 0, 2, 1};  // LSR 9 mod 8
    vecs[14] = '{3'd6, 8'h3C, 8'd8,  8'h3D, 0, 1, 1, 0, 2, 0};  // MSK 8 mod 8
`endif

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_values("reset");
    $display("reset: busy=%b done=%b result=%02h", Busy, Done, Result);
    Reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_op(i, vecs[i], 0);

    // Start with opcode 0 during a STEP cycle must be dropped
    v = vecs[1];
    run_op(100, v, 2);

    // Reset during STEP of LSL B=5: immediate IDLE, reset values, no Done
    @(negedge Clk);
    Start = 1'b1; OpIn = 3'd1; A = 8'h01; B = 8'd5;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    check("midrst_in_step", {29'd0, Busy, AluOp}, {29'd0, 1'b1, 3'd1});
    Reset_n = 1'b0;
    @(negedge Clk);
    check_reset_values("midrst");
    Reset_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (Done || Busy) saw_done = 1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    $display("midrst: busy=%b done=%b result=%02h", Busy, Done, Result);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
